spi_slave: RTL and testbench

Serial front end of the SPI-slave/single-port-RAM subsystem. Deserialises MOSI frames into 10-bit command words for the RAM (`rx_data`/`rx_valid`). For read-data commands, captures the RAM's 8-bit response (`tx_data`/`tx_valid`) and serialises it MSB-first on MISO. The SPI clock is the system clock `clk`; SS_n framing is sampled synchronously.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_piso.sv | 93 +++++++++
 rtl/spi_slave.sv | 114 +++++++++++
 tb/tb_spi_slave.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-slave / single-port-RAM subsystem:
// frame widths, the front-end FSM state type and the RAM opcode values.
package spi_pkg;

  localparam int CMD_W  = 10;  // 2-bit opcode plus 8-bit payload
  localparam int DATA_W = 8;   // read-back data width

  // Opcodes carried in rx_data[9:8]; decoded by the RAM, not by the front end.
  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

endpackage

// File: rtl/spi_piso.sv
// MISO serialiser: loads one read byte and shifts it out MSB-first, one bit
// per cycle, then drives 0. With SPI_TX_PARITY_EN defined, an odd-parity bit
// (XNOR-reduce of the byte) follows the 8th data bit. done_o pulses in the
// cycle whose closing edge returns MISO to 0 after a completed byte.
module spi_piso
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              miso_o,
  output logic              done_o
);

  logic [DATA_W-2:0] sh_q, sh_d;       // bits still to send after the MSB
  logic [3:0]        left_q, left_d;   // data bits remaining in sh_q
  logic              miso_q, miso_d;
  logic              active_q, active_d;
`ifdef SPI_TX_PARITY_EN
  logic              par_q, par_d;
  logic              par_pend_q, par_pend_d;
`endif

  // Next-state logic for load / shift / drain of the serialiser.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    sh_d     = sh_q;
    left_d   = left_q;
    miso_d   = 1'b0;
    active_d = active_q;
    done_o   = 1'b0;
`ifdef SPI_TX_PARITY_EN
    par_d      = par_q;
    par_pend_d = par_pend_q;
`endif
    if (clear_i) begin
      left_d   = 4'd0;
      active_d = 1'b0;
`ifdef SPI_TX_PARITY_EN
      par_pend_d = 1'b0;
`endif
    end else if (load_i) begin
      miso_d   = data_i[DATA_W-1];
      sh_d     = data_i[DATA_W-2:0];
      left_d   = 4'(DATA_W - 1);
      active_d = 1'b1;
`ifdef SPI_TX_PARITY_EN
      par_d      = ~^data_i;
      par_pend_d = 1'b1;
`endif
    end else if (left_q != 4'd0) begin
      miso_d = sh_q[DATA_W-2];
      sh_d   = {sh_q[DATA_W-3:0], 1'b0};
      left_d = left_q - 4'd1;
`ifdef SPI_TX_PARITY_EN
    end else if (par_pend_q) begin
      miso_d     = par_q;
      par_pend_d = 1'b0;
`endif
    end else if (active_q) begin
      active_d = 1'b0;
      done_o   = 1'b1;
    end
  end

  // Serialiser registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q     <= '0;
      left_q   <= 4'd0;
      miso_q   <= 1'b0;
      active_q <= 1'b0;
`ifdef SPI_TX_PARITY_EN
      par_q      <= 1'b0;
      par_pend_q <= 1'b0;
`endif
    end else begin
      sh_q     <= sh_d;
      left_q   <= left_d;
      miso_q   <= miso_d;
      active_q <= active_d;
`ifdef SPI_TX_PARITY_EN
      par_q      <= par_d;
      par_pend_q <= par_pend_d;
`endif
    end
  end

  assign miso_o = miso_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises 10-bit MOSI command frames into rx_data
// with a one-cycle rx_valid, and for read-data frames serialises the RAM's
// tx_data byte on MISO. Optional MISO parity bit: SPI_TX_PARITY_EN.
module spi_slave
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              MOSI,
  input  logic              SS_n,
  output logic              MISO,
  output logic [CMD_W-1:0]  rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  // Bit counter codes within a data state.
  localparam logic [3:0] CNT_LAST = 4'd8;   // sampling bit 0 of the frame
  localparam logic [3:0] CNT_WAIT = 4'd9;   // frame done, waiting / holding
  localparam logic [3:0] CNT_SENT = 4'd10;  // read byte captured for MISO

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [CMD_W-2:0]   shreg_q, shreg_d;     // bits 9..1 while a frame arrives
  logic [CMD_W-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               seen_q, seen_d;       // rd_addr_seen
  logic               piso_load, piso_clear, piso_done;

  // FSM next state, frame deserialisation and read-response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    seen_d     = seen_q;
    piso_load  = 1'b0;
    piso_clear = 1'b0;

    if (piso_done) seen_d = 1'b0;

    if (state_q == IDLE) begin
      if (!SS_n) begin
        state_d = CHK_CMD;
        cnt_d   = 4'd0;
      end
    end else if (SS_n) begin
      // Abort: partial frames are dropped and MISO is silenced.
      state_d    = IDLE;
      cnt_d      = 4'd0;
      piso_clear = 1'b1;
    end else begin
      case (state_q)
        CHK_CMD: begin
          shreg_d = {{(CMD_W-2){1'b0}}, MOSI};
          if (!MOSI)       state_d = WRITE;
          else if (seen_q) state_d = READ_DATA;
          else             state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (cnt_q < CNT_LAST) begin
            shreg_d = {shreg_q[CMD_W-3:0], MOSI};
            cnt_d   = cnt_q + 4'd1;
          end else if (cnt_q == CNT_LAST) begin
            rx_data_d  = {shreg_q, MOSI};
            rx_valid_d = 1'b1;
            cnt_d      = CNT_WAIT;
            if (state_q == READ_ADD) seen_d = 1'b1;
          end else if (state_q == READ_DATA && cnt_q == CNT_WAIT && tx_valid) begin
            piso_load = 1'b1;
            cnt_d     = CNT_SENT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and frame registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      seen_q     <= seen_d;
    end
  end

  spi_piso u_piso (
    .clk     (clk),
    .rst     (rst),
    .clear_i (piso_clear),
    .load_i  (piso_load),
    .data_i  (tx_data),
    .miso_o  (MISO),
    .done_o  (piso_done)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: reset, write frames, read
// address/data sequence with MISO byte, abort with back-to-back frame, and a
// read-data frame with no RAM response.
module tb_spi_slave;
  import spi_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              MOSI;
  logic              SS_n;
  logic              MISO;
  logic [CMD_W-1:0]  rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SPI_TX_PARITY_EN
  localparam logic PAR_EXP = 1'b1;  // odd parity of 8'hC3
`else
  localparam logic PAR_EXP = 1'b0;
`endif

  spi_slave dut (
    .clk      (clk),
    .rst      (rst),
    .MOSI     (MOSI),
    .SS_n     (SS_n),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full frame starting from IDLE; returns just after edge 10.
  task automatic run_frame(input string tag, input logic [9:0] bits, input state_e exp_st);
    int early_valid;
    int miso_hi;
    early_valid = 0;
    miso_hi     = 0;
    SS_n = 1'b0;
    step();                              // edge 0
    for (int i = 9; i >= 0; i--) begin
      MOSI = bits[i];
      step();                            // edges 1..10
      if (i == 9) check({tag, "_state"}, 32'(dut.state_q), 32'(exp_st));
      if (i > 0 && rx_valid) early_valid++;
      if (MISO) miso_hi++;
    end
    check({tag, "_valid"}, 32'(rx_valid), 32'd1);
    check({tag, "_data"}, 32'(rx_data), 32'(bits));
    check({tag, "_early_valid"}, 32'(early_valid), 32'd0);
    check({tag, "_miso_quiet"}, 32'(miso_hi), 32'd0);
  endtask

  task automatic end_frame(input string tag);
    SS_n = 1'b1;
    MOSI = 1'b0;
    step();
    check({tag, "_idle"}, 32'(dut.state_q), 32'(IDLE));
  endtask

  initial begin
    int cnt;
    logic [7:0] byte_exp;

    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
    step(); step();
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    check("rst_seen", 32'(dut.seen_q), 32'd0);
    rst = 1'b0;
    step();

    // Reset asserted at edge 5 of a write frame (bits 00_1010_0101).
    SS_n = 1'b0;
    step();                              // edge 0
    MOSI = 1'b0; step();                 // edge 1
    MOSI = 1'b0; step();                 // edge 2
    MOSI = 1'b1; step();                 // edge 3
    MOSI = 1'b0; step();                 // edge 4
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b1;
    step();                              // edge 5
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_data", 32'(rx_data), 32'd0);
    check("midrst_miso", 32'(MISO), 32'd0);
    check("midrst_cnt", 32'(dut.cnt_q), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rx_valid) cnt++;
    end
    check("midrst_no_valid", 32'(cnt), 32'd0);

    // Write-address frame.
    run_frame("wr_addr", 10'b00_1010_0101, WRITE);
    step();
    check("wr_addr_pulse_end", 32'(rx_valid), 32'd0);
    check("wr_addr_hold", 32'(rx_data), 32'h0A5);
    end_frame("wr_addr");

    // Write-data frame with a stray tx_valid held high throughout.
    tx_valid = 1'b1; tx_data = 8'hFF;
    run_frame("wr_data", 10'b01_0011_1100, WRITE);
    step(); step();
    check("wr_data_stray_tx_miso", 32'(MISO), 32'd0);
    check("wr_data_seen", 32'(dut.seen_q), 32'd0);
    tx_valid = 1'b0; tx_data = 8'h00;
    end_frame("wr_data");

    // Read address then read data with 8'hC3 returned.
    run_frame("rd_addr", 10'b10_0000_0111, READ_ADD);
    step();
    check("rd_addr_seen", 32'(dut.seen_q), 32'd1);
    end_frame("rd_addr");
    run_frame("rd_data", 10'b11_0000_0000, READ_DATA);
    step();                              // edge 11
    check("rd_data_pulse_end", 32'(rx_valid), 32'd0);
    tx_valid = 1'b1; tx_data = 8'hC3;
    step();                              // edge 12 captures
    tx_valid = 1'b0; tx_data = 8'h00;
    byte_exp = 8'hC3;
    for (int b = 7; b >= 0; b--) begin
      check($sformatf("rd_data_miso_b%0d", b), 32'(MISO), 32'(byte_exp[b]));
      step();
    end
    check("rd_data_parity_slot", 32'(MISO), 32'(PAR_EXP));
    step();
    check("rd_data_miso_tail", 32'(MISO), 32'd0);
    check("rd_data_seen_clr", 32'(dut.seen_q), 32'd0);
    check("rd_data_hold_state", 32'(dut.state_q), 32'(READ_DATA));
    end_frame("rd_data");

    // Abort after 4 bits, then a back-to-back full frame.
    SS_n = 1'b0;
    step();
    MOSI = 1'b0; step();
    MOSI = 1'b1; step();
    MOSI = 1'b1; step();
    MOSI = 1'b0; step();
    SS_n = 1'b1;
    step();
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_valid", 32'(rx_valid), 32'd0);
    check("abort_data_held", 32'(rx_data), 32'h300);
    check("abort_seen", 32'(dut.seen_q), 32'd0);
    run_frame("after_abort", 10'b00_1111_1111, WRITE);
    end_frame("after_abort");

    // Read-data frame with no RAM response.
    run_frame("nr_addr", 10'b10_1010_1010, READ_ADD);
    end_frame("nr_addr");
    run_frame("nr_data", 10'b11_1111_1111, READ_DATA);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (MISO || dut.state_q != READ_DATA) cnt++;
    end
    check("nr_wait", 32'(cnt), 32'd0);
    end_frame("nr_data");
    check("nr_seen_kept", 32'(dut.seen_q), 32'd1);
    check("nr_miso", 32'(MISO), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
